// File: rtl/alu_issue_ctrl_pkg.sv
// ============================================================================
//  Module   : alu_issue_ctrl_pkg
//  Purpose  : ALU opcodes, ISA constants, FSM/decode types for alu_issue_ctrl
//  Revision : 1.0
// ============================================================================
`default_nettype none

package alu_issue_ctrl_pkg;

    // ALU opcodes shared with the 16-bit ALU
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ID   = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_LRS  = 4'd10;
    localparam logic [3:0] OP_ARS  = 4'd11;
    localparam logic [3:0] OP_RR   = 4'd12;
    localparam logic [3:0] OP_LLS  = 4'd13;
    localparam logic [3:0] OP_ALS  = 4'd14;
    localparam logic [3:0] OP_RL   = 4'd15;

    localparam logic [3:0] OPC_RTYPE = 4'd15;
    localparam logic [3:0] OPC_ADI   = 4'd4;
    localparam logic [3:0] OPC_LHI   = 4'd6;
    localparam logic [5:0] FUNC_ADD  = 6'd0;
    localparam logic [5:0] FUNC_WWD  = 6'd28;

    // LHI is executed as imm << LHI_SHAMT on the ALU shifter
    localparam int LHI_SHAMT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_ILL = 3'd0,
        K_ADD = 3'd1,
        K_WWD = 3'd2,
        K_ADI = 3'd3,
        K_LHI = 3'd4
    } kind_t;

    function automatic kind_t decode(input logic [15:0] i);
        kind_t k;
        k = K_ILL;
        if (i[15:12] == OPC_RTYPE && i[5:0] == FUNC_ADD)      k = K_ADD;
        else if (i[15:12] == OPC_RTYPE && i[5:0] == FUNC_WWD) k = K_WWD;
        else if (i[15:12] == OPC_ADI)                         k = K_ADI;
        else if (i[15:12] == OPC_LHI)                         k = K_LHI;
        return k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_reg_file.sv
// ============================================================================
//  Module   : reg_file_4x16
//  Purpose  : Register file, 2 async read ports, 1 sync write port, async reset
//  Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_4x16 #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RADDR_W-1:0] raddr0,
    input  logic [RADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0]  rdata0,
    output logic [DATA_W-1:0]  rdata1,
    input  logic               wen,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata
);

    localparam int DEPTH = 1 << RADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (wen) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata0 = r_mem[raddr0];
    assign rdata1 = r_mem[raddr1];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Non-overlapped issue/writeback controller in front of a 16b ALU
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [15:0]       inst,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_cout,
    output logic [DATA_W-1:0] output_port,
    output logic              carry_flag,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  num_inst
);

    state_t            r_state;
    kind_t             r_kind;
    logic [15:0]       r_inst;
    logic [DATA_W-1:0] r_result;
    logic              r_cout;

    kind_t              w_kind;
    logic [DATA_W-1:0]  w_rdata0;
    logic [DATA_W-1:0]  w_rdata1;
    logic [DATA_W-1:0]  w_imm_sext;
    logic [DATA_W-1:0]  w_imm_zext;
    logic               w_wen;
    logic [RADDR_W-1:0] w_waddr;

    assign w_kind     = decode(inst);
    assign w_imm_sext = {{(DATA_W-8){inst[7]}}, inst[7:0]};
    assign w_imm_zext = {{(DATA_W-8){1'b0}}, inst[7:0]};

    assign w_wen   = (r_state == ST_WB) &&
                     (r_kind == K_ADD || r_kind == K_ADI || r_kind == K_LHI);
    assign w_waddr = (r_kind == K_ADD) ? RADDR_W'(r_inst[7:6]) : RADDR_W'(r_inst[9:8]);

    // Operands are read off the incoming inst; the file is stable while IDLE
    reg_file_4x16 #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .raddr0 (RADDR_W'(inst[11:10])),
        .raddr1 (RADDR_W'(inst[9:8])),
        .rdata0 (w_rdata0),
        .rdata1 (w_rdata1),
        .wen    (w_wen),
        .waddr  (w_waddr),
        .wdata  (r_result)
    );

    assign inst_ready = (r_state == ST_IDLE);
    assign alu_cin    = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_kind      <= K_ILL;
            r_inst      <= '0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            output_port <= '0;
            carry_flag  <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            num_inst    <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (inst_valid) begin
                        r_inst  <= inst;
                        r_kind  <= w_kind;
                        r_state <= ST_EXEC;
                        // ALU drive is registered so it is valid for all of EXEC
                        case (w_kind)
                            K_ADD: begin
                                alu_a  <= w_rdata0;
                                alu_b  <= w_rdata1;
                                alu_op <= OP_ADD;
                            end
                            K_WWD: begin
                                alu_a  <= w_rdata0;
                                alu_op <= OP_ID;
                            end
                            K_ADI: begin
                                alu_a  <= w_rdata0;
                                alu_b  <= w_imm_sext;
                                alu_op <= OP_ADD;
                            end
                            K_LHI: begin
                                alu_a  <= w_imm_zext;
                                alu_b  <= DATA_W'(LHI_SHAMT);
                                alu_op <= OP_LLS;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    r_result <= alu_c;
                    r_cout   <= alu_cout;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    r_state  <= ST_IDLE;
                    done     <= 1'b1;
                    illegal  <= (r_kind == K_ILL);
                    num_inst <= num_inst + 1'b1;
                    if (r_kind == K_WWD) output_port <= r_result;
                    if (r_kind == K_ADD || r_kind == K_ADI) carry_flag <= r_cout;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
